// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and pipeline_ctrl.
// Status flows datapath->controller; stage Wr/Flush and PC redirect flow back.
interface pipeline_ctrl_if;
  logic        ICacheBusy;
  logic        DCacheBusy;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic        EXE_IsLoad;
  logic [4:0]  EXE_rt;
  logic        EXE_DivStart;
  logic        EXE_BranchFail;
  logic [31:0] EXE_BranchAddr;
  logic        MEM_ExcValid;
  logic [31:0] MEM_ExcVector;

  logic        PC_Wr;
  logic        ID_Wr;
  logic        EXE_Wr;
  logic        MEM_Wr;
  logic        WB_Wr;
  logic        ID_Flush;
  logic        EXE_Flush;
  logic        MEM_Flush;
  logic        WB_Flush;
  logic        PC_Redirect;
  logic [31:0] RedirectAddr;
  logic        DivBusy;

  // Controller side: commands the stage registers.
  modport master (
    input  ICacheBusy, DCacheBusy, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
           EXE_IsLoad, EXE_rt, EXE_DivStart, EXE_BranchFail, EXE_BranchAddr,
           MEM_ExcValid, MEM_ExcVector,
    output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
           ID_Flush, EXE_Flush, MEM_Flush, WB_Flush,
           PC_Redirect, RedirectAddr, DivBusy
  );

  // Datapath side: reports hazards, obeys Wr/Flush.
  modport slave (
    output ICacheBusy, DCacheBusy, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
           EXE_IsLoad, EXE_rt, EXE_DivStart, EXE_BranchFail, EXE_BranchAddr,
           MEM_ExcValid, MEM_ExcVector,
    input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
           ID_Flush, EXE_Flush, MEM_Flush, WB_Flush,
           PC_Redirect, RedirectAddr, DivBusy
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect controller for the 5-stage core; outputs are combinational (0 cycles).
// Exceptions and branch redirects wait in state until the I-cache can accept the new PC.
module pipeline_ctrl #(
  parameter int DIV_CYCLES = 36
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.master io_pipe
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_EXC_WAIT = 2'd2
  } state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_br_pend, w_br_pend_n;
  logic [31:0]      r_pend_addr, w_pend_addr_n;

  logic w_load_use;
  logic w_exc;
  logic w_div_wait;
  logic w_div_busy_cnt;
  logic w_br_seen;

  assign w_load_use = io_pipe.EXE_IsLoad && (io_pipe.EXE_rt != 5'd0) &&
                      ((io_pipe.ID_UseRs && (io_pipe.ID_rs == io_pipe.EXE_rt)) ||
                       (io_pipe.ID_UseRt && (io_pipe.ID_rt == io_pipe.EXE_rt)));
  assign w_exc          = io_pipe.MEM_ExcValid || (r_state == ST_EXC_WAIT);
  assign w_div_wait     = (r_state == ST_DIV_WAIT);
  assign w_div_busy_cnt = w_div_wait && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_br_pend   <= 1'b0;
      r_pend_addr <= 32'd0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_br_pend   <= w_br_pend_n;
      r_pend_addr <= w_pend_addr_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_br_pend_n   = r_br_pend;
    w_pend_addr_n = r_pend_addr;
    w_br_seen     = 1'b0;

    io_pipe.PC_Wr        = 1'b1;
    io_pipe.ID_Wr        = 1'b1;
    io_pipe.EXE_Wr       = 1'b1;
    io_pipe.MEM_Wr       = 1'b1;
    io_pipe.WB_Wr        = 1'b1;
    io_pipe.ID_Flush     = 1'b0;
    io_pipe.EXE_Flush    = 1'b0;
    io_pipe.MEM_Flush    = 1'b0;
    io_pipe.WB_Flush     = 1'b0;
    io_pipe.PC_Redirect  = 1'b0;
    io_pipe.RedirectAddr = r_pend_addr;
    io_pipe.DivBusy      = 1'b0;

    if (rst) begin
      io_pipe.PC_Wr     = 1'b0;
      io_pipe.ID_Wr     = 1'b0;
      io_pipe.EXE_Wr    = 1'b0;
      io_pipe.MEM_Wr    = 1'b0;
      io_pipe.WB_Wr     = 1'b0;
      io_pipe.ID_Flush  = 1'b1;
      io_pipe.EXE_Flush = 1'b1;
      io_pipe.MEM_Flush = 1'b1;
      io_pipe.WB_Flush  = 1'b1;
    end else if (w_exc) begin
      // Exception kills any divide and any pending branch redirect.
      w_cnt_n     = '0;
      w_br_pend_n = 1'b0;
      if (io_pipe.ICacheBusy) begin
        if (r_state != ST_EXC_WAIT) begin
          w_pend_addr_n = io_pipe.MEM_ExcVector;
        end
        w_state_n        = ST_EXC_WAIT;
        io_pipe.PC_Wr    = 1'b0;
        io_pipe.ID_Wr    = 1'b0;
        io_pipe.EXE_Wr   = 1'b0;
        io_pipe.MEM_Wr   = 1'b0;
        io_pipe.WB_Flush = 1'b1;
      end else begin
        w_state_n            = ST_RUN;
        io_pipe.PC_Redirect  = 1'b1;
        io_pipe.RedirectAddr = (r_state == ST_EXC_WAIT) ? r_pend_addr
                                                        : io_pipe.MEM_ExcVector;
        io_pipe.ID_Flush     = 1'b1;
        io_pipe.EXE_Flush    = 1'b1;
        io_pipe.MEM_Flush    = 1'b1;
        io_pipe.WB_Flush     = 1'b1;
      end
    end else begin
      // The divider keeps counting through memory stalls.
      if (w_div_busy_cnt) begin
        w_cnt_n = r_cnt - 1'b1;
      end

      if (io_pipe.DCacheBusy) begin
        io_pipe.PC_Wr    = 1'b0;
        io_pipe.ID_Wr    = 1'b0;
        io_pipe.EXE_Wr   = 1'b0;
        io_pipe.MEM_Wr   = 1'b0;
        io_pipe.WB_Flush = 1'b1;
        io_pipe.DivBusy  = w_div_busy_cnt;
      end else if (((r_state == ST_RUN) && io_pipe.EXE_DivStart) || w_div_busy_cnt) begin
        if (r_state == ST_RUN) begin
          w_cnt_n   = DIV_LOAD;
          w_state_n = ST_DIV_WAIT;
        end
        io_pipe.PC_Wr     = 1'b0;
        io_pipe.ID_Wr     = 1'b0;
        io_pipe.EXE_Wr    = 1'b0;
        io_pipe.MEM_Flush = 1'b1;
        io_pipe.DivBusy   = 1'b1;
      end else begin
        if (w_div_wait) begin
          w_state_n = ST_RUN;
        end

        if (w_load_use) begin
          io_pipe.PC_Wr     = 1'b0;
          io_pipe.ID_Wr     = 1'b0;
          io_pipe.EXE_Flush = 1'b1;
        end else if (io_pipe.ICacheBusy) begin
          io_pipe.PC_Wr    = 1'b0;
          io_pipe.ID_Flush = 1'b1;
        end

        if (io_pipe.EXE_BranchFail) begin
          w_br_seen = 1'b1;
          if (!io_pipe.ICacheBusy) begin
            // Under load-use the delay slot stays held in ID instead of being flushed.
            io_pipe.PC_Redirect  = 1'b1;
            io_pipe.RedirectAddr = io_pipe.EXE_BranchAddr;
            io_pipe.PC_Wr        = 1'b1;
            io_pipe.ID_Flush     = !w_load_use;
            w_br_pend_n          = 1'b0;
          end else begin
            w_br_pend_n   = 1'b1;
            w_pend_addr_n = io_pipe.EXE_BranchAddr;
          end
        end
      end

      if (r_br_pend && !io_pipe.ICacheBusy && !w_br_seen) begin
        io_pipe.PC_Redirect  = 1'b1;
        io_pipe.RedirectAddr = r_pend_addr;
        io_pipe.ID_Flush     = 1'b1;
        w_br_pend_n          = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: each cycle's expected controls are queued at drive time
// and popped/compared mid-cycle once the combinational outputs have settled.
module tb_pipeline_ctrl;

  // {PC,ID,EXE,MEM,WB}_Wr , {ID,EXE,MEM,WB}_Flush
  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_RST  = 9'b00000_1111;
  localparam logic [8:0] C_LU   = 9'b00111_0100;
  localparam logic [8:0] C_ICB  = 9'b01111_1000;
  localparam logic [8:0] C_DIV  = 9'b00011_0010;
  localparam logic [8:0] C_DCB  = 9'b00001_0001;
  localparam logic [8:0] C_EXCW = 9'b00001_0001;
  localparam logic [8:0] C_EXCR = 9'b11111_1111;
  localparam logic [8:0] C_BRR  = 9'b11111_1000;
  localparam logic [8:0] C_BRLU = 9'b10111_0100;

  typedef struct packed {
    logic [8:0]  ctl;
    logic        redir;
    logic [31:0] addr;
    logic        divb;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string cur = "init";

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.DIV_CYCLES(36)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_pipe (pif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    pif.ICacheBusy     = 1'b0;
    pif.DCacheBusy     = 1'b0;
    pif.ID_rs          = 5'd0;
    pif.ID_rt          = 5'd0;
    pif.ID_UseRs       = 1'b0;
    pif.ID_UseRt       = 1'b0;
    pif.EXE_IsLoad     = 1'b0;
    pif.EXE_rt         = 5'd0;
    pif.EXE_DivStart   = 1'b0;
    pif.EXE_BranchFail = 1'b0;
    pif.EXE_BranchAddr = 32'd0;
    pif.MEM_ExcValid   = 1'b0;
    pif.MEM_ExcVector  = 32'd0;
  endtask

  // Queue the expectation for the inputs just driven, then compare at the falling edge.
  task automatic cyc(input logic [8:0] ctl, input logic redir, input logic [31:0] addr, input logic divb);
    exp_t e;
    sb_q.push_back('{ctl: ctl, redir: redir, addr: addr, divb: divb});
    @(negedge clk);
    e = sb_q.pop_front();
    chk({cur, ".ctl"}, 32'({pif.PC_Wr, pif.ID_Wr, pif.EXE_Wr, pif.MEM_Wr, pif.WB_Wr,
                            pif.ID_Flush, pif.EXE_Flush, pif.MEM_Flush, pif.WB_Flush}), 32'(e.ctl));
    chk({cur, ".redir"}, 32'(pif.PC_Redirect), 32'(e.redir));
    if (e.redir) chk({cur, ".raddr"}, pif.RedirectAddr, e.addr);
    chk({cur, ".divbusy"}, 32'(pif.DivBusy), 32'(e.divb));
    @(posedge clk);
    #1;
  endtask

  // Divide pulse in cycle 1 (plus an ignored re-start in cycle 5); optional D-cache stall and reset.
  task automatic run_div(input bit with_dc, input int rst_at);
    for (int c = 1; c <= 36; c++) begin
      cur = $sformatf("div%0d_c%0d", with_dc, c);
      pif.EXE_DivStart = (c == 1) || (c == 5);
      pif.DCacheBusy   = with_dc && (c >= 10) && (c <= 12);
      rst              = (c == rst_at);
      if (c == rst_at) begin
        cyc(C_RST, 1'b0, 32'd0, 1'b0);
        break;
      end else if (pif.DCacheBusy) cyc(C_DCB, 1'b0, 32'd0, 1'b1);
      else if (c < 36)             cyc(C_DIV, 1'b0, 32'd0, 1'b1);
      else                         cyc(C_NORM, 1'b0, 32'd0, 1'b0);
    end
    idle();
    rst = 1'b0;
    cur = "div_after";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    cur = "reset";
    cyc(C_RST, 1'b0, 32'd0, 1'b0);
    cyc(C_RST, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    cur = "idle";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    cur = "lu_rs";
    pif.EXE_IsLoad = 1'b1; pif.EXE_rt = 5'd5; pif.ID_rs = 5'd5; pif.ID_UseRs = 1'b1;
    cyc(C_LU, 1'b0, 32'd0, 1'b0);
    idle(); cur = "lu_after";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);
    cur = "lu_rt";
    pif.EXE_IsLoad = 1'b1; pif.EXE_rt = 5'd7; pif.ID_rt = 5'd7; pif.ID_UseRt = 1'b1;
    cyc(C_LU, 1'b0, 32'd0, 1'b0);
    cur = "lu_nouse";
    pif.ID_UseRt = 1'b0; pif.ID_rs = 5'd7;
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);
    cur = "lu_r0";
    idle(); pif.EXE_IsLoad = 1'b1; pif.ID_UseRs = 1'b1;
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);
    cur = "lu_icb";
    pif.EXE_rt = 5'd9; pif.ID_rs = 5'd9; pif.ICacheBusy = 1'b1;
    cyc(C_LU, 1'b0, 32'd0, 1'b0);
    idle(); cur = "icb";
    pif.ICacheBusy = 1'b1;
    cyc(C_ICB, 1'b0, 32'd0, 1'b0);
    idle();

    run_div(1'b0, 0);
    run_div(1'b1, 0);
    run_div(1'b0, 10);

    cur = "exc_fetch";
    pif.MEM_ExcValid = 1'b1; pif.MEM_ExcVector = 32'hBFC0_0380; pif.ICacheBusy = 1'b1;
    cyc(C_EXCW, 1'b0, 32'd0, 1'b0);
    pif.MEM_ExcValid = 1'b0; pif.MEM_ExcVector = 32'h1234_5678;
    cyc(C_EXCW, 1'b0, 32'd0, 1'b0);
    cyc(C_EXCW, 1'b0, 32'd0, 1'b0);
    pif.ICacheBusy = 1'b0; cur = "exc_redir";
    cyc(C_EXCR, 1'b1, 32'hBFC0_0380, 1'b0);
    idle(); cur = "exc_after";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    cur = "exc_div";
    pif.EXE_DivStart = 1'b1;
    cyc(C_DIV, 1'b0, 32'd0, 1'b1);
    pif.EXE_DivStart = 1'b0;
    cyc(C_DIV, 1'b0, 32'd0, 1'b1);
    pif.MEM_ExcValid = 1'b1; pif.MEM_ExcVector = 32'h8000_0180;
    cyc(C_EXCR, 1'b1, 32'h8000_0180, 1'b0);
    idle(); cur = "exc_div_after";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    cur = "br_pend";
    pif.EXE_BranchFail = 1'b1; pif.EXE_BranchAddr = 32'h8000_1000; pif.ICacheBusy = 1'b1;
    cyc(C_ICB, 1'b0, 32'd0, 1'b0);
    pif.EXE_BranchFail = 1'b0; pif.EXE_BranchAddr = 32'h0;
    cyc(C_ICB, 1'b0, 32'd0, 1'b0);
    pif.ICacheBusy = 1'b0; cur = "br_release";
    cyc(C_BRR, 1'b1, 32'h8000_1000, 1'b0);
    cur = "br_cleared";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    cur = "br_overwrite";
    pif.EXE_BranchFail = 1'b1; pif.EXE_BranchAddr = 32'h8000_2000; pif.ICacheBusy = 1'b1;
    cyc(C_ICB, 1'b0, 32'd0, 1'b0);
    pif.EXE_BranchAddr = 32'h8000_3000;
    cyc(C_ICB, 1'b0, 32'd0, 1'b0);
    idle();
    cyc(C_BRR, 1'b1, 32'h8000_3000, 1'b0);

    cur = "br_now";
    pif.EXE_BranchFail = 1'b1; pif.EXE_BranchAddr = 32'h8000_4444;
    cyc(C_BRR, 1'b1, 32'h8000_4444, 1'b0);
    cur = "br_lu";
    pif.EXE_IsLoad = 1'b1; pif.EXE_rt = 5'd3; pif.ID_rt = 5'd3; pif.ID_UseRt = 1'b1;
    pif.EXE_BranchAddr = 32'h8000_5550;
    cyc(C_BRLU, 1'b1, 32'h8000_5550, 1'b0);
    idle(); cur = "br_dcb";
    pif.EXE_BranchFail = 1'b1; pif.EXE_BranchAddr = 32'h8000_6000; pif.DCacheBusy = 1'b1;
    cyc(C_DCB, 1'b0, 32'd0, 1'b0);
    idle(); cur = "br_dcb_after";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    cur = "br_exc_busy";
    pif.EXE_BranchFail = 1'b1; pif.EXE_BranchAddr = 32'h8000_7000;
    pif.MEM_ExcValid = 1'b1; pif.MEM_ExcVector = 32'hBFC0_0380; pif.ICacheBusy = 1'b1;
    cyc(C_EXCW, 1'b0, 32'd0, 1'b0);
    idle();
    cyc(C_EXCR, 1'b1, 32'hBFC0_0380, 1'b0);
    cur = "br_exc_nopend";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);
    cur = "br_exc_now";
    pif.EXE_BranchFail = 1'b1; pif.EXE_BranchAddr = 32'h8000_8000;
    pif.MEM_ExcValid = 1'b1; pif.MEM_ExcVector = 32'h8000_0180;
    cyc(C_EXCR, 1'b1, 32'h8000_0180, 1'b0);
    idle();
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    cur = "rst_excw";
    pif.MEM_ExcValid = 1'b1; pif.MEM_ExcVector = 32'hBFC0_0200; pif.ICacheBusy = 1'b1;
    cyc(C_EXCW, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    cyc(C_RST, 1'b0, 32'd0, 1'b0);
    rst = 1'b0; idle(); cur = "rst_excw_after";
    cyc(C_NORM, 1'b0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
